// File: rtl/mac_alu.sv
// Multi-function ALU: single-cycle add and popcount-dot, plus shift-add multiply and
// multiply-accumulate with a sticky accumulator overflow flag.
module mac_alu #(
    parameter int WIDTH = 4,
    parameter int ACC_W = 3*WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] result,
    output logic             acc_ovf
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam int PW = 2*WIDTH;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             is_mac;
    logic [PW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [PW-1:0]    prod;
    logic [ACC_W-1:0] acc;

    logic [PW-1:0]    prod_nxt;
    logic [ACC_W:0]   mac_sum;
    logic [WIDTH:0]   add_sum;
    logic [CW-1:0]    pop;

    always_comb begin
        prod_nxt = prod + (mplier[0] ? mcand : '0);
        mac_sum  = {1'b0, acc} + (ACC_W+1)'(prod_nxt);
        add_sum  = {1'b0, a} + {1'b0, b};
        pop      = '0;
        for (int i = 0; i < WIDTH; i++)
            pop = pop + CW'(a[i] & b[i]);
    end

    // acc is written only on the final multiply step, so an abort by reset never
    // leaves a partial accumulation behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            acc       <= '0;
            acc_ovf   <= 1'b0;
            cnt       <= '0;
            is_mac    <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            prod      <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    if (acc_clr) begin
                        acc     <= '0;
                        acc_ovf <= 1'b0;
                    end
                    in_ready <= 1'b0;
                    case (op)
                        2'b00: begin
                            result    <= ACC_W'(add_sum);
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                        2'b10: begin
                            result    <= ACC_W'(pop);
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                        default: begin
                            mcand  <= PW'(a);
                            mplier <= b;
                            prod   <= '0;
                            cnt    <= '0;
                            is_mac <= op[1];
                            state  <= MUL;
                        end
                    endcase
                end
                MUL: begin
                    prod   <= prod_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH-1)) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                        if (is_mac) begin
                            acc     <= mac_sum[ACC_W-1:0];
                            result  <= mac_sum[ACC_W-1:0];
                            acc_ovf <= acc_ovf | mac_sum[ACC_W];
                        end else begin
                            result <= ACC_W'(prod_nxt);
                        end
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_alu.sv
// Directed bench for mac_alu (WIDTH=4, ACC_W=12); expectations are hand-computed.
module tb_mac_alu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  op = 2'b00;
    logic [3:0]  a = '0, b = '0;
    logic        acc_clr = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [11:0] result;
    logic        acc_ovf;

    int checks = 0;
    int failures = 0;

    mac_alu #(.WIDTH(4), .ACC_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .acc_clr(acc_clr), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .acc_ovf(acc_ovf)
    );

    always #5 clk = ~clk;

    // Issues one request from a negedge, then counts negedges until out_valid
    // (lat) and how many of those cycles had in_ready low (busy).
    task automatic do_req(input logic [1:0] o, input logic [3:0] va, input logic [3:0] vb,
                          input logic clr, output logic [11:0] res, output int lat,
                          output int busy);
        int w;
        w = 0;
        while (!in_ready && w < 30) begin
            @(negedge clk);
            w++;
        end
        op = o; a = va; b = vb; acc_clr = clr; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; acc_clr = 1'b0;
        lat = 0; busy = 0; res = 'x;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (!in_ready) busy++;
            if (out_valid) begin
                res = result;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #12;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (result !== 12'd0) begin failures++; $display("FAIL reset_result got=%0d exp=0", result); end
        checks++; if (acc_ovf !== 1'b0) begin failures++; $display("FAIL reset_acc_ovf got=%b exp=0", acc_ovf); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add;
        logic [11:0] r; int lat, busy;
        do_req(2'b00, 4'd15, 4'd15, 1'b0, r, lat, busy);
        checks++; if (r !== 12'd30) begin failures++; $display("FAIL add_result got=%0d exp=30", r); end
        checks++; if (lat !== 1) begin failures++; $display("FAIL add_latency got=%0d exp=1", lat); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL add_one_cycle_valid got=%b exp=0", out_valid); end
        do_req(2'b00, 4'd9, 4'd4, 1'b0, r, lat, busy);
        checks++; if (r !== 12'd13) begin failures++; $display("FAIL add_9_4 got=%0d exp=13", r); end
    endtask

    task automatic test_mul;
        logic [11:0] r; int lat, busy;
        @(negedge clk);
        do_req(2'b01, 4'd13, 4'd11, 1'b0, r, lat, busy);
        checks++; if (r !== 12'd143) begin failures++; $display("FAIL mul_result got=%0d exp=143", r); end
        checks++; if (lat !== 5) begin failures++; $display("FAIL mul_latency got=%0d exp=5", lat); end
        checks++; if (busy !== 5) begin failures++; $display("FAIL mul_busy_cycles got=%0d exp=5", busy); end
        @(negedge clk);
        do_req(2'b01, 4'd0, 4'd7, 1'b0, r, lat, busy);
        checks++; if (r !== 12'd0) begin failures++; $display("FAIL mul_zero got=%0d exp=0", r); end
        @(negedge clk);
        do_req(2'b01, 4'd15, 4'd15, 1'b0, r, lat, busy);
        checks++; if (r !== 12'd225) begin failures++; $display("FAIL mul_max got=%0d exp=225", r); end
    endtask

    task automatic test_dot;
        logic [11:0] r; int lat, busy;
        @(negedge clk);
        do_req(2'b10, 4'b1011, 4'b0110, 1'b0, r, lat, busy);
        checks++; if (r !== 12'd1) begin failures++; $display("FAIL dot_1011_0110 got=%0d exp=1", r); end
        checks++; if (lat !== 1) begin failures++; $display("FAIL dot_latency got=%0d exp=1", lat); end
        @(negedge clk);
        do_req(2'b10, 4'b1111, 4'b1111, 1'b0, r, lat, busy);
        checks++; if (r !== 12'd4) begin failures++; $display("FAIL dot_1111 got=%0d exp=4", r); end
    endtask

    task automatic test_mac_wrap;
        logic [11:0] r; int lat, busy; int exp_full;
        for (int i = 1; i <= 19; i++) begin
            @(negedge clk);
            do_req(2'b11, 4'd15, 4'd15, (i == 1), r, lat, busy);
            exp_full = 225 * i;
            checks++; if (r !== 12'(exp_full % 4096)) begin failures++; $display("FAIL mac_step%0d got=%0d exp=%0d", i, r, exp_full % 4096); end
            checks++; if (acc_ovf !== (exp_full >= 4096)) begin failures++; $display("FAIL mac_ovf_step%0d got=%b exp=%b", i, acc_ovf, exp_full >= 4096); end
        end
        // Non-MAC ops must not disturb the overflow flag without acc_clr.
        @(negedge clk);
        do_req(2'b01, 4'd2, 4'd2, 1'b0, r, lat, busy);
        checks++; if (acc_ovf !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", acc_ovf); end
        @(negedge clk);
        do_req(2'b00, 4'd1, 4'd2, 1'b1, r, lat, busy);
        checks++; if (acc_ovf !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", acc_ovf); end
        checks++; if (r !== 12'd3) begin failures++; $display("FAIL clr_add_result got=%0d exp=3", r); end
        @(negedge clk);
        do_req(2'b11, 4'd1, 4'd1, 1'b0, r, lat, busy);
        checks++; if (r !== 12'd1) begin failures++; $display("FAIL mac_after_clr got=%0d exp=1", r); end
        @(negedge clk);
        do_req(2'b01, 4'd7, 4'd7, 1'b0, r, lat, busy);
        @(negedge clk);
        do_req(2'b10, 4'd7, 4'd7, 1'b0, r, lat, busy);
        @(negedge clk);
        do_req(2'b11, 4'd3, 4'd5, 1'b0, r, lat, busy);
        checks++; if (r !== 12'd16) begin failures++; $display("FAIL acc_untouched_by_mul_dot got=%0d exp=16", r); end
        // acc_clr without an accepted request is ignored.
        @(negedge clk);
        acc_clr = 1'b1;
        repeat (2) @(negedge clk);
        acc_clr = 1'b0;
        do_req(2'b11, 4'd1, 4'd2, 1'b0, r, lat, busy);
        checks++; if (r !== 12'd18) begin failures++; $display("FAIL idle_clr_ignored got=%0d exp=18", r); end
    endtask

    task automatic test_backpressure;
        logic [11:0] r; int lat, busy;
        @(negedge clk);
        out_ready = 1'b0;
        do_req(2'b00, 4'd7, 4'd9, 1'b0, r, lat, busy);
        checks++; if (r !== 12'd16) begin failures++; $display("FAIL bp_result got=%0d exp=16", r); end
        op = 2'b00; a = 4'd1; b = 4'd1; acc_clr = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1 || result !== 12'd16 || in_ready !== 1'b0) begin
                failures++; $display("FAIL bp_hold cyc=%0d got v=%b r=%0d rdy=%b exp v=1 r=16 rdy=0", i, out_valid, result, in_ready);
            end
        end
        in_valid = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_release got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready); end
        // The held acc_clr must not have been taken: acc continues from 18.
        do_req(2'b11, 4'd1, 4'd1, 1'b0, r, lat, busy);
        checks++; if (r !== 12'd19) begin failures++; $display("FAIL bp_no_accept got=%0d exp=19", r); end
    endtask

    task automatic test_back_to_back;
        logic [11:0] r; int lat, busy;
        @(negedge clk);
        op = 2'b00; a = 4'd2; b = 4'd3; in_valid = 1'b1;
        @(posedge clk);
        #1 a = 4'd4; b = 4'd4;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || result !== 12'd5 || in_ready !== 1'b0) begin failures++; $display("FAIL b2b_first got v=%b r=%0d rdy=%b exp v=1 r=5 rdy=0", out_valid, result, in_ready); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL b2b_gap got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || result !== 12'd8) begin failures++; $display("FAIL b2b_second got v=%b r=%0d exp v=1 r=8", out_valid, result); end
        @(negedge clk);
        r = 0; lat = 0; busy = 0;
    endtask

    task automatic test_reset_mid_mul;
        logic [11:0] r; int lat, busy;
        @(negedge clk);
        op = 2'b11; a = 4'd15; b = 4'd15; acc_clr = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 12'd0 || acc_ovf !== 1'b0) begin
            failures++; $display("FAIL mid_reset got rdy=%b v=%b r=%0d ovf=%b exp 1 0 0 0", in_ready, out_valid, result, acc_ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_req(2'b11, 4'd2, 4'd3, 1'b0, r, lat, busy);
        checks++; if (r !== 12'd6) begin failures++; $display("FAIL mac_after_reset got=%0d exp=6", r); end
        checks++; if (lat !== 5) begin failures++; $display("FAIL mac_latency got=%0d exp=5", lat); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_dot();
        test_mac_wrap();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_mul();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mac_alu.md
MAC_ALU -- requirements
Module: mac_alu

Interface
REQ-001 Parameter WIDTH, default 4: operand width in bits; legal range 2..16.
REQ-002 Parameter ACC_W, default 3*WIDTH: accumulator and result width; SHALL be at least 2*WIDTH.
REQ-003 Port clk  input  1: single clock; all state SHALL update on the rising edge.
REQ-004 Port rst_n  input  1: asynchronous active-low reset.
REQ-005 Port in_valid  input  1: request present.
REQ-006 Port in_ready  output  1: block can accept a request.
REQ-007 Port op  input  2: 00 add, 01 multiply, 10 dot, 11 multiply-accumulate (MAC).
REQ-008 Port a, b  input  WIDTH each: unsigned operands.
REQ-009 Port acc_clr  input  1: clears the accumulator as part of the accepted request.
REQ-010 Port out_valid  output  1: result present.
REQ-011 Port out_ready  input  1: consumer takes the result.
REQ-012 Port result  output  ACC_W: unsigned result, zero-extended.
REQ-013 Port acc_ovf  output  1: sticky accumulator overflow flag.

Function
REQ-014 A request SHALL be accepted on a rising edge where in_valid && in_ready; op, a, b and acc_clr SHALL be captured at that edge.
REQ-015 FSM states SHALL be IDLE, MUL and DONE; in_ready SHALL be 1 only in IDLE.
REQ-016 Transitions: IDLE, accept of add or dot -> DONE; IDLE, accept of mul or MAC -> MUL; MUL after WIDTH iterations -> DONE; DONE with out_ready -> IDLE.
REQ-017 add: result = a + b (WIDTH+1 bits, zero-extended); out_valid SHALL rise one cycle after accept.
REQ-018 dot: result = popcount(a & b); out_valid SHALL rise one cycle after accept.
REQ-019 mul: shift-add, one multiplier bit per cycle, LSB first; result = a*b (2*WIDTH bits) with out_valid rising WIDTH+1 cycles after accept.
REQ-020 MAC: same timing as mul; acc <= acc + a*b modulo 2^ACC_W; result = new acc value.
REQ-021 acc_clr=1 on an accepted MAC SHALL use 0 as the prior acc value, so result = a*b.
REQ-022 acc_clr=1 on an accepted add, mul or dot SHALL set acc to 0 at the accept edge without affecting that result.
REQ-023 acc_clr SHALL be ignored when no request is accepted.
REQ-024 acc_ovf SHALL set when a MAC sum carries out of ACC_W bits; it SHALL clear only on reset or an accepted acc_clr.
REQ-025 Only MAC SHALL modify acc; add, mul and dot SHALL leave acc unchanged, except for REQ-022.
REQ-026 In DONE, result and out_valid SHALL hold stable while out_ready=0.
REQ-027 In DONE with out_ready=1, out_valid SHALL drop at the next edge; a new accept is possible the following cycle. Back-to-back throughput is 1 request per 2 cycles for add and dot.
REQ-028 out_ready SHALL be ignored when out_valid=0.
REQ-029 in_valid in MUL or DONE SHALL not be accepted; the requester holds the request until in_ready.

Reset
REQ-030 With rst_n=0, state SHALL be IDLE, in_ready=1, out_valid=0, result=0, acc=0, acc_ovf=0, and the iteration counter SHALL be 0, independent of clk.
REQ-031 Reset asserted in MUL or DONE SHALL abort the operation and discard the result; acc SHALL not be partially updated.
REQ-032 The first accept is allowed on the first rising edge after rst_n deasserts.

Verification (WIDTH=4, ACC_W=12)
REQ-033 Add: op=00, a=15, b=15, out_ready=1 -> result=30 and out_valid high for one cycle, one cycle after accept.
REQ-034 Mul: op=01, a=13, b=11 -> in_ready=0 for 5 cycles; result=143, out_valid 5 cycles after accept.
REQ-035 Dot: op=10, a=4'b1011, b=4'b0110 -> result=1; then a=b=4'b1111 -> result=4.
REQ-036 MAC with wrap: first acc_clr=1, a=b=15 -> 225; then 18 more MACs, a=b=15, acc_clr=0 -> results 450, ..., 4050, then 4275 mod 4096=179 with acc_ovf=1; then acc_clr=1, op=00 -> acc_ovf=0.
REQ-037 Backpressure: out_ready=0 for 10 cycles in DONE -> result and out_valid stable, in_ready=0, in_valid ignored; out_ready=1 -> return to IDLE.
REQ-038 Reset mid-MUL: assert rst_n=0 two cycles after a MAC accept -> all outputs at reset values immediately; acc=0 on the next MAC with acc_clr=0.
